light_mode_decoder: RTL and testbench
=====================================

Name: light_mode_decoder

Overview:
Receive-side counterpart of the bike-light state encoder. Takes the 2-bit encoded mode code, glitch-filters it, and decodes it back to a one-hot mode state. Generates the physical light waveform for that mode: off, steady on, blink, or PWM-dimmed. Sits between the encoded mode bus and the light LED pin in the FPGA top level.

Parameters:
FILTER_CYCLES, 2, consecutive identical code samples required to accept a new mode (>=1)
BLINK_HALF, 62500000, clock cycles per blink half-period (0.5 s at 125 MHz), >=1
BLINK_CNT_W, 27, width of the blink counter; must hold BLINK_HALF-1
DIM_PERIOD, 16, PWM period in clocks for DIM mode, >=1
DIM_DUTY, 4, PWM high clocks per period; 0 means always low, >=DIM_PERIOD means always high

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
code  input  2  encoded mode: 00 OFF, 01 ON, 10 BLINK, 11 DIM (bit0 = state[1]|state[3], bit1 = state[2]|state[3])
state  output  4  one-hot decoded mode: 0001 OFF, 0010 ON, 0100 BLINK, 1000 DIM
light_out  output  1  light drive, registered
mode_changed  output  1  one-cycle pulse when an accepted mode differs from the previous mode

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. All outputs are registered.
- Reset assertion acts immediately, without a clock edge, including mid-operation. Reset values:
  - state = 0001, light_out = 0, mode_changed = 0
  - filter sample = 00, filter count = 0
  - blink counter = 0, blink phase = 1, PWM counter = 0
- After reset release with code = 00: no mode_changed pulse.
- Glitch filter: each edge samples code.
  - Sample equals previous sample: count increments, saturating at FILTER_CYCLES.
  - Sample differs: count = 1 and the sample is stored.
  - The code is accepted on the edge where count reaches FILTER_CYCLES.
  - With FILTER_CYCLES=1, every sample is accepted.
  - A new code held fewer than FILTER_CYCLES samples is ignored entirely.
- Acceptance latency: new code first sampled at edge k -> state updates at edge k+FILTER_CYCLES-1.
- Mode change (accepted code decodes to a different state), all on the same edge:
  - state takes the new one-hot value.
  - mode_changed = 1 for exactly one cycle.
  - Blink counter and PWM counter reset to 0; blink phase reset to 1.
  - light_out takes the first value of the new mode: OFF 0, ON 1, BLINK 1, DIM (DIM_DUTY>0).
- Re-acceptance of the current mode: no pulse, counters not disturbed.
- Waveforms, per edge while in mode:
  - OFF: light_out = 0.
  - ON: light_out = 1.
  - BLINK: counter increments. At BLINK_HALF-1 the counter wraps to 0 and the phase toggles. light_out = phase as of that edge, so each level lasts exactly BLINK_HALF cycles.
  - DIM: PWM counter runs 0..DIM_PERIOD-1 and wraps. light_out = 1 when the counter's value after the edge is < DIM_DUTY. Each period has exactly DIM_DUTY (clamped to DIM_PERIOD) high cycles.
- Counters are held at 0 in modes that do not use them.
- Simultaneous events:
  - Mode change on the same edge as a blink wrap or PWM wrap: mode change wins, and counters reset.
  - Reset wins over everything.
- state is always exactly one-hot, never 0000.

Test Plan:
(Bench params: FILTER_CYCLES=2, BLINK_HALF=3, DIM_PERIOD=4, DIM_DUTY=1.)
1. Reset: hold reset_n=0 with code=11, then release and keep code=00 -> state=0001, light_out=0, mode_changed never high; assert reset_n mid-BLINK between edges -> outputs return to reset values immediately.
2. Latency: code 00->01 sampled at edge k -> state=0010, light_out=1, mode_changed=1 after edge k+1; mode_changed=0 after edge k+2.
3. Glitch: code=10 for one cycle then back to 00 -> state stays 0001, no pulse; code=10 for two cycles -> state=0100.
4. Blink: enter BLINK -> light_out pattern 1,1,1,0,0,0,1,1,1... from the change edge; switch to ON mid-low-phase -> light_out=1 at the acceptance edge.
5. Dim: enter DIM -> light_out repeating 1,0,0,0; switch DIM->BLINK->DIM -> each entry restarts at 1 with one mode_changed pulse per switch.
6. Re-accept: code 01 held 20 cycles -> exactly one mode_changed pulse; code 01->11->01 with 11 held 1 cycle -> no pulse.

Source files
------------

// File: rtl/light_mode_decoder.sv
// Receive-side bike-light mode decoder: glitch-filters the 2-bit mode code,
// decodes it to a one-hot state and drives the matching light waveform.
module light_mode_decoder #(
    parameter int unsigned FILTER_CYCLES = 2,
    parameter int unsigned BLINK_HALF    = 62500000,
    parameter int unsigned BLINK_CNT_W   = 27,
    parameter int unsigned DIM_PERIOD    = 16,
    parameter int unsigned DIM_DUTY      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] code,
    output logic [3:0] state,
    output logic       light_out,
    output logic       mode_changed
);

    localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned PWM_W  = (DIM_PERIOD > 1) ? $clog2(DIM_PERIOD) : 1;

    localparam logic [FILT_W-1:0]      FILT_FULL  = FILT_W'(FILTER_CYCLES);
    localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_HALF - 1);
    localparam logic [PWM_W-1:0]       PWM_LAST   = PWM_W'(DIM_PERIOD - 1);

    localparam logic [3:0] ST_OFF   = 4'b0001;
    localparam logic [3:0] ST_ON    = 4'b0010;
    localparam logic [3:0] ST_BLINK = 4'b0100;
    localparam logic [3:0] ST_DIM   = 4'b1000;

    logic [1:0]             filt_sample_q, filt_sample_d;
    logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                   blink_phase_q, blink_phase_d;
    logic [PWM_W-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [3:0]             state_d, code_state;
    logic                   light_d, changed_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        filt_sample_d = filt_sample_q;
        filt_cnt_d    = filt_cnt_q;
        state_d       = state;
        light_d       = 1'b0;
        changed_d     = 1'b0;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
        pwm_cnt_d     = '0;
        code_state    = ST_OFF << code;

        if (code == filt_sample_q) begin
            if (filt_cnt_q != FILT_FULL) filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end else begin
            filt_sample_d = code;
            filt_cnt_d    = FILT_W'(1);
        end

        // A real mode change restarts every waveform generator from its first cycle.
        if (filt_cnt_d == FILT_FULL && code_state != state) begin
            state_d   = code_state;
            changed_d = 1'b1;
            light_d   = (code_state == ST_ON) || (code_state == ST_BLINK) ||
                        ((code_state == ST_DIM) && (DIM_DUTY != 0));
        end else begin
            case (state)
                ST_ON: light_d = 1'b1;
                ST_BLINK: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        blink_cnt_d   = blink_cnt_q + BLINK_CNT_W'(1);
                        blink_phase_d = blink_phase_q;
                    end
                    light_d = blink_phase_d;
                end
                ST_DIM: begin
                    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
                    light_d   = (32'(pwm_cnt_d) < DIM_DUTY);
                end
                default: light_d = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_sample_q <= 2'b00;
            filt_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pwm_cnt_q     <= '0;
            state         <= ST_OFF;
            light_out     <= 1'b0;
            mode_changed  <= 1'b0;
        end else begin
            filt_sample_q <= filt_sample_d;
            filt_cnt_q    <= filt_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            state         <= state_d;
            light_out     <= light_d;
            mode_changed  <= changed_d;
        end
    end

endmodule

// File: tb/tb_light_mode_decoder.sv
// Self-checking bench for light_mode_decoder: table of per-edge vectors plus
// hand-written sequences for reset, re-acceptance and glitch corners.
module tb_light_mode_decoder;

    localparam int unsigned FC = 2;
    localparam int unsigned BH = 3;
    localparam int unsigned BW = 2;
    localparam int unsigned DP = 4;
    localparam int unsigned DD = 1;

    localparam logic [3:0] S_OFF = 4'b0001;
    localparam logic [3:0] S_ON  = 4'b0010;
    localparam logic [3:0] S_BLK = 4'b0100;
    localparam logic [3:0] S_DIM = 4'b1000;

    typedef struct {
        logic [1:0] code;
        logic [3:0] st;
        logic       lt;
        logic       ch;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] code = 2'b11;
    logic [3:0] state;
    logic       light_out;
    logic       mode_changed;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    light_mode_decoder #(
        .FILTER_CYCLES(FC),
        .BLINK_HALF   (BH),
        .BLINK_CNT_W  (BW),
        .DIM_PERIOD   (DP),
        .DIM_DUTY     (DD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .code        (code),
        .state       (state),
        .light_out   (light_out),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] c, input logic [3:0] s, input logic l, input logic m);
        vec_t v;
        v.code = c;
        v.st   = s;
        v.lt   = l;
        v.ch   = m;
        vecs.push_back(v);
    endtask

    // Drive code, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input logic [1:0] c);
        code = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;

        // Reset, OFF idle, latency
        add(2'b00, S_OFF, 0, 0); add(2'b00, S_OFF, 0, 0); add(2'b00, S_OFF, 0, 0);
        add(2'b01, S_OFF, 0, 0); add(2'b01, S_ON,  1, 1); add(2'b01, S_ON,  1, 0);
        add(2'b00, S_ON,  1, 0); add(2'b00, S_OFF, 0, 1);
        // One-cycle glitch ignored, then a real BLINK request
        add(2'b10, S_OFF, 0, 0); add(2'b00, S_OFF, 0, 0); add(2'b00, S_OFF, 0, 0);
        add(2'b10, S_OFF, 0, 0); add(2'b10, S_BLK, 1, 1);
        add(2'b10, S_BLK, 1, 0); add(2'b10, S_BLK, 1, 0); add(2'b10, S_BLK, 0, 0);
        add(2'b10, S_BLK, 0, 0); add(2'b10, S_BLK, 0, 0); add(2'b10, S_BLK, 1, 0);
        add(2'b10, S_BLK, 1, 0); add(2'b10, S_BLK, 1, 0); add(2'b10, S_BLK, 0, 0);
        // Switch to ON while blink is low
        add(2'b01, S_BLK, 0, 0); add(2'b01, S_ON,  1, 1);
        // DIM waveform 1,0,0,0
        add(2'b11, S_ON,  1, 0); add(2'b11, S_DIM, 1, 1);
        add(2'b11, S_DIM, 0, 0); add(2'b11, S_DIM, 0, 0); add(2'b11, S_DIM, 0, 0);
        add(2'b11, S_DIM, 1, 0); add(2'b11, S_DIM, 0, 0);
        // DIM -> BLINK -> DIM; second change lands on a blink wrap edge
        add(2'b10, S_DIM, 0, 0); add(2'b10, S_BLK, 1, 1); add(2'b10, S_BLK, 1, 0);
        add(2'b11, S_BLK, 1, 0); add(2'b11, S_DIM, 1, 1); add(2'b11, S_DIM, 0, 0);
        // One-cycle glitch in DIM; re-acceptance must not disturb the PWM
        add(2'b01, S_DIM, 0, 0); add(2'b11, S_DIM, 0, 0); add(2'b11, S_DIM, 1, 0);

        // Reset held with code=11 drives outputs to reset values
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(state), 32'(S_OFF));
        check("reset light", 32'(light_out), 0);
        check("reset changed", 32'(mode_changed), 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].code);
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d light", i), 32'(light_out), 32'(vecs[i].lt));
            check($sformatf("vec%0d changed", i), 32'(mode_changed), 32'(vecs[i].ch));
        end

        // Code 01 held 20 cycles from DIM: exactly one pulse
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(2'b01);
            if (mode_changed === 1'b1) pulses++;
        end
        check("reaccept pulses", 32'(pulses), 1);
        check("reaccept state", 32'(state), 32'(S_ON));

        // 01 -> 11 (one cycle) -> 01: no pulse, stays ON
        pulses = 0;
        step(2'b11);
        if (mode_changed === 1'b1) pulses++;
        for (int i = 0; i < 6; i++) begin
            step(2'b01);
            if (mode_changed === 1'b1) pulses++;
        end
        check("glitch11 pulses", 32'(pulses), 0);
        check("glitch11 state", 32'(state), 32'(S_ON));
        check("glitch11 light", 32'(light_out), 1);

        // Enter BLINK, then assert reset between edges: immediate effect
        step(2'b10);
        step(2'b10);
        check("pre-reset state", 32'(state), 32'(S_BLK));
        check("pre-reset changed", 32'(mode_changed), 1);
        #2;
        code    = 2'b00;
        reset_n = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'(S_OFF));
        check("async reset light", 32'(light_out), 0);
        check("async reset changed", 32'(mode_changed), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // After release with code=00: no pulse, stays OFF and dark
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(2'b00);
            if (mode_changed === 1'b1) pulses++;
        end
        check("post-reset pulses", 32'(pulses), 0);
        check("post-reset state", 32'(state), 32'(S_OFF));
        check("post-reset light", 32'(light_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
